// File: rtl/ex_fwd_mov_stage.sv
// ID/EX + EX/MEM pipeline slice: operand forwarding by register compare, load-use
// detection, ADD/SUB/AND/ORR/EOR and MOVZ/MOVK/MOVN execution, registered result for MEM.
module ex_fwd_mov_stage #(
    parameter int WIDTH  = 64,
    parameter int HW     = 16,
    parameter int REG_AW = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [REG_AW-1:0]           id_rn,
    input  logic [REG_AW-1:0]           id_rm,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic [WIDTH-1:0]            id_da,
    input  logic [WIDTH-1:0]            id_db,
    input  logic [WIDTH-1:0]            id_imm,
    input  logic                        id_use_imm,
    input  logic [HW-1:0]               id_imm16,
    input  logic [$clog2(WIDTH/HW)-1:0] id_hw,
    input  logic [2:0]                  id_op,
    input  logic                        id_regwrite,
    input  logic                        id_memread,
    input  logic                        id_memwrite,
    input  logic                        id_setflags,
    input  logic                        wb_valid,
    input  logic                        wb_regwrite,
    input  logic [REG_AW-1:0]           wb_rd,
    input  logic [WIDTH-1:0]            wb_data,
    input  logic                        mem_stall,
    input  logic                        flush,
    output logic                        stall_req,
    output logic                        ex_valid,
    output logic                        ex_regwrite,
    output logic                        ex_memread,
    output logic                        ex_memwrite,
    output logic [REG_AW-1:0]           ex_rd,
    output logic [WIDTH-1:0]            ex_result,
    output logic [WIDTH-1:0]            ex_store_data,
    output logic                        negative,
    output logic                        zero,
    output logic                        overflow,
    output logic                        carry
);
    localparam int HWW = $clog2(WIDTH/HW);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [REG_AW-1:0] XZR = '1;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_ORR  = 3'b011,
        OP_EOR  = 3'b100,
        OP_MOVZ = 3'b101,
        OP_MOVK = 3'b110,
        OP_MOVN = 3'b111
    } op_e;

    logic              idex_valid_reg;
    logic [REG_AW-1:0] idex_rn_reg, idex_rm_reg, idex_rd_reg;
    logic [WIDTH-1:0]  idex_da_reg, idex_db_reg, idex_imm_reg;
    logic              idex_use_imm_reg;
    logic [HW-1:0]     idex_imm16_reg;
    logic [HWW-1:0]    idex_hw_reg;
    op_e               idex_op_reg;
    logic              idex_regwrite_reg, idex_memread_reg, idex_memwrite_reg, idex_setflags_reg;

    assign stall_req = id_valid & idex_valid_reg & idex_memread_reg & (idex_rd_reg != XZR)
                     & ((idex_rd_reg == id_rn) | (idex_rd_reg == id_rm));

    logic [REG_AW-1:0] src_reg [2];
    logic [WIDTH-1:0]  src_rf  [2];
    assign src_reg[0] = idex_rn_reg;
    assign src_reg[1] = idex_rm_reg;
    assign src_rf[0]  = idex_da_reg;
    assign src_rf[1]  = idex_db_reg;

    // A loaded value is not yet in ex_result, so a load in EX/MEM is never a forward source.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [WIDTH-1:0] val;
            logic             ex_hit, wb_hit;
            assign ex_hit = ex_valid & ex_regwrite & ~ex_memread & (ex_rd == src_reg[gi]);
            assign wb_hit = wb_valid & wb_regwrite & (wb_rd == src_reg[gi]);
            always_comb begin
                if (src_reg[gi] == XZR)
                    val = '0;
                else if (ex_hit)
                    val = ex_result;
                else if (wb_hit)
                    val = wb_data;
                else
                    val = src_rf[gi];
            end
        end
    endgenerate

    logic [WIDTH-1:0] op_a, b_src, op_b;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] imm_sh, hw_mask;
    logic [WIDTH-1:0] result_next;
    logic             carry_next, overflow_next;

    assign op_a    = g_fwd[0].val;
    assign b_src   = g_fwd[1].val;
    assign op_b    = idex_use_imm_reg ? idex_imm_reg : b_src;
    assign sum     = {1'b0, op_a} + {1'b0, op_b};
    assign diff    = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt   = SHW'(idex_hw_reg) * SHW'(HW);
    assign imm_sh  = {{(WIDTH-HW){1'b0}}, idex_imm16_reg} << shamt;
    assign hw_mask = {{(WIDTH-HW){1'b0}}, {HW{1'b1}}} << shamt;

    always_comb begin
        result_next   = sum[WIDTH-1:0];
        carry_next    = sum[WIDTH];
        overflow_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
        // Loads and stores always compute the address, whatever the op field says.
        if (!(idex_memread_reg | idex_memwrite_reg)) begin
            case (idex_op_reg)
                OP_ADD: ;
                OP_SUB: begin
                    result_next   = diff[WIDTH-1:0];
                    carry_next    = diff[WIDTH];
                    overflow_next = (op_a[WIDTH-1] != op_b[WIDTH-1]) & (diff[WIDTH-1] != op_a[WIDTH-1]);
                end
                OP_AND:  result_next = op_a & op_b;
                OP_ORR:  result_next = op_a | op_b;
                OP_EOR:  result_next = op_a ^ op_b;
                OP_MOVZ: result_next = imm_sh;
                OP_MOVK: result_next = (b_src & ~hw_mask) | imm_sh;
                OP_MOVN: result_next = ~imm_sh;
                default: ;
            endcase
            if (idex_op_reg != OP_ADD && idex_op_reg != OP_SUB) begin
                carry_next    = 1'b0;
                overflow_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idex_valid_reg    <= 1'b0;
            idex_regwrite_reg <= 1'b0;
            idex_memread_reg  <= 1'b0;
            idex_memwrite_reg <= 1'b0;
            idex_setflags_reg <= 1'b0;
            ex_valid          <= 1'b0;
            ex_regwrite       <= 1'b0;
            ex_memread        <= 1'b0;
            ex_memwrite       <= 1'b0;
            ex_rd             <= '0;
            ex_result         <= '0;
            ex_store_data     <= '0;
            negative          <= 1'b0;
            zero              <= 1'b0;
            overflow          <= 1'b0;
            carry             <= 1'b0;
        end else begin
            if (!mem_stall) begin
                ex_valid      <= idex_valid_reg;
                ex_regwrite   <= idex_valid_reg & idex_regwrite_reg;
                ex_memread    <= idex_valid_reg & idex_memread_reg;
                ex_memwrite   <= idex_valid_reg & idex_memwrite_reg;
                ex_rd         <= idex_rd_reg;
                ex_result     <= result_next;
                ex_store_data <= b_src;
                if (idex_valid_reg && idex_setflags_reg) begin
                    negative <= result_next[WIDTH-1];
                    zero     <= (result_next == '0);
                    overflow <= overflow_next;
                    carry    <= carry_next;
                end
            end
            // Flush wins even while memory is busy; a load-use stall only matters when moving.
            if (flush || (!mem_stall && stall_req)) begin
                idex_valid_reg <= 1'b0;
            end else if (!mem_stall) begin
                idex_valid_reg    <= id_valid;
                idex_rn_reg       <= id_rn;
                idex_rm_reg       <= id_rm;
                idex_rd_reg       <= id_rd;
                idex_da_reg       <= id_da;
                idex_db_reg       <= id_db;
                idex_imm_reg      <= id_imm;
                idex_use_imm_reg  <= id_use_imm;
                idex_imm16_reg    <= id_imm16;
                idex_hw_reg       <= id_hw;
                idex_op_reg       <= op_e'(id_op);
                idex_regwrite_reg <= id_regwrite;
                idex_memread_reg  <= id_memread;
                idex_memwrite_reg <= id_memwrite;
                idex_setflags_reg <= id_setflags;
            end
        end
    end
endmodule
